// File: rtl/toggle_period_meter.sv
// toggle_period_meter: measures sys_clk cycles between successive transitions of an
// asynchronous toggling input and reports each half-period. It declares lock after
// LOCK_N consecutive in-tolerance half-periods and flags loss of toggling.
// Optional feature macro: TPM_ERR_CNT_EN adds the saturating err_cnt output.
module toggle_period_meter #(
  parameter int unsigned       CNT_W    = 26,
  parameter logic [CNT_W-1:0]  EXP_HALF = CNT_W'(25_000_000),
  parameter logic [CNT_W-1:0]  TOL      = CNT_W'(1_000),
  parameter int unsigned       LOCK_N   = 4,
  parameter logic [CNT_W-1:0]  TMO_CYC  = CNT_W'(50_000_000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_half,
  output logic             meas_valid,
  output logic             in_lock,
  output logic             timeout
`ifdef TPM_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEAS   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Tolerance window computed one bit wider so the upper bound cannot wrap;
  // the lower bound clamps at zero when TOL exceeds EXP_HALF.
  localparam logic [CNT_W:0] TOL_HI   = {1'b0, EXP_HALF} + {1'b0, TOL};
  localparam logic [CNT_W:0] TOL_LO   = (EXP_HALF > TOL) ? {1'b0, EXP_HALF - TOL} : '0;
  localparam logic [4:0]     LOCK_N_L = 5'(LOCK_N);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_match;
  state_t           r_state;

  logic             w_edge;
  logic [CNT_W-1:0] w_meas;
  logic             w_in_tol;
  logic             w_lock_hit;

  function automatic logic [3:0] sat_match(input logic [3:0] m);
    return (m == 4'hF) ? m : m + 4'd1;
  endfunction

`ifdef TPM_ERR_CNT_EN
  function automatic logic [7:0] sat_err(input logic [7:0] e);
    return (e == 8'hFF) ? e : e + 8'd1;
  endfunction
`endif

  // Edge detect on the synchronised input, measured length and window test
  always_comb begin
    w_edge     = r_sync2 ^ r_prev;
    w_meas     = r_count + CNT_W'(1);
    w_in_tol   = ({1'b0, w_meas} >= TOL_LO) && ({1'b0, w_meas} <= TOL_HI);
    w_lock_hit = ({1'b0, r_match} + 5'd1) >= LOCK_N_L;
  end

  // Synchroniser, interval counter, lock FSM and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_count    <= '0;
      r_match    <= '0;
      r_state    <= ST_IDLE;
      meas_half  <= '0;
      meas_valid <= 1'b0;
      in_lock    <= 1'b0;
      timeout    <= 1'b0;
`ifdef TPM_ERR_CNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      r_sync1    <= sig_in;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      meas_valid <= 1'b0;
      if (w_edge) begin
        // An edge always restarts the interval and wins over a coincident timeout
        r_count <= '0;
        timeout <= 1'b0;
        if (r_state == ST_IDLE) begin
          r_state <= ST_MEAS;
        end else begin
          meas_half  <= w_meas;
          meas_valid <= 1'b1;
          if (w_in_tol) begin
            r_match <= sat_match(r_match);
            if (w_lock_hit) begin
              r_state <= ST_LOCKED;
              in_lock <= 1'b1;
            end
          end else begin
            r_match <= '0;
            in_lock <= 1'b0;
            r_state <= ST_MEAS;
`ifdef TPM_ERR_CNT_EN
            err_cnt <= sat_err(err_cnt);
`endif
          end
        end
      end else if (r_count == TMO_CYC) begin
        // Count is pinned at TMO_CYC; the next edge becomes a fresh reference
        timeout <= 1'b1;
        in_lock <= 1'b0;
        r_match <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Scoreboard bench for toggle_period_meter (CNT_W=8, EXP_HALF=10, TOL=1, LOCK_N=3, TMO_CYC=40).
module tb_toggle_period_meter;

  localparam int EXP = 10;
  localparam int TOLV = 1;
  localparam int LOCKN = 3;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic [7:0] meas_half;
  logic       meas_valid;
  logic       in_lock;
  logic       timeout;
`ifdef TPM_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  toggle_period_meter #(
    .CNT_W(8), .EXP_HALF(8'd10), .TOL(8'd1), .LOCK_N(3), .TMO_CYC(8'd40)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .sig_in(sig),
    .meas_half(meas_half), .meas_valid(meas_valid),
    .in_lock(in_lock), .timeout(timeout)
`ifdef TPM_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int meas;
    int lock;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: abstract counts, not RTL state
  bit have_ref = 0;
  int run = 0;        // consecutive in-tolerance measurements
  int err_m = 0;
  int tmo_exp = 0;
  int tmo_seen = 0;
  bit prev_tmo = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Waits gap cycles after the previous toggle, toggles, and updates the model
  task automatic toggle_after(input int gap);
    exp_t e;
    for (int c = 0; c < gap; c++) begin
      @(posedge clk);
      if (gap >= 48 && c == gap - 2) begin
        #1;
        check("timeout_level", int'(timeout), 1);
        check("timeout_unlock", int'(in_lock), 0);
      end
    end
    #1 sig = ~sig;
    if (!have_ref) begin
      have_ref = 1;
    end else if (gap > TMO + 1) begin
      tmo_exp++;
      run = 0;
    end else begin
      if (gap >= EXP - TOLV && gap <= EXP + TOLV) begin
        run++;
      end else begin
        run = 0;
        if (err_m < 255) err_m++;
      end
      e.meas = gap;
      e.lock = (run >= LOCKN) ? 1 : 0;
      e.err  = err_m;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    if (sig) toggle_after(10);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_meas_half", int'(meas_half), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_in_lock", int'(in_lock), 0);
    check("rst_timeout", int'(timeout), 0);
`ifdef TPM_ERR_CNT_EN
    check("rst_err_cnt", int'(err_cnt), 0);
`endif
    have_ref = 0;
    run = 0;
    err_m = 0;
  endtask

  // Monitor: pops the expected record whenever the DUT presents a measurement
  always @(negedge clk) begin
    if (!rst) begin
      if (timeout && !prev_tmo) tmo_seen++;
      prev_tmo <= timeout;
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("meas_half", int'(meas_half), e.meas);
          check("in_lock", int'(in_lock), e.lock);
          check("timeout_at_pulse", int'(timeout), 0);
`ifdef TPM_ERR_CNT_EN
          check("err_cnt", int'(err_cnt), e.err);
`endif
        end
      end
    end else begin
      prev_tmo <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("init_meas_half", int'(meas_half), 0);
    check("init_in_lock", int'(in_lock), 0);
    check("init_timeout", int'(timeout), 0);

    // Regular toggling, lock on the third measurement
    toggle_after(3);
    repeat (6) toggle_after(10);
    // Window edges while locked, then a miss and relock
    toggle_after(9);
    toggle_after(11);
    toggle_after(12);
    repeat (3) toggle_after(10);
    toggle_after(8);
    repeat (4) toggle_after(10);
    // Loss of toggling, then recovery
    toggle_after(50);
    toggle_after(10);
    repeat (4) toggle_after(10);
    // Reset while locked, mid-period
    do_reset();
    toggle_after(3);
    repeat (4) toggle_after(10);
    // Edge coincident with count saturation beats timeout; one cycle later times out
    toggle_after(TMO + 1);
    toggle_after(10);
    toggle_after(TMO + 2);
    repeat (4) toggle_after(10);

    // Randomised spacings
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      g = $urandom_range(9, 11);
      else if (r < 90) g = $urandom_range(2, 20);
      else if (r < 95) g = $urandom_range(39, 43);
      else             g = $urandom_range(48, 55);
      toggle_after(g);
    end

`ifdef TPM_ERR_CNT_EN
    do_reset();
    toggle_after(3);
    repeat (5) toggle_after(14);
    repeat (300) toggle_after(14);
`endif

    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("timeout_events", tmo_seen, tmo_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
